lemming_track: RTL and testbench



---
 rtl/lemming_track_if.sv | 29 ++
 rtl/lemming_track.sv | 98 +++++++++
 tb/tb_lemming_track.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lemming_track_if.sv
// Bundle between the lemming track model and its host: walker direction,
// wall-map write port and the track status returned to the walker.
interface lemming_track_if #(
  parameter int TRACK_LEN = 16
) ();
  localparam int AW = $clog2(TRACK_LEN);

  logic          enable;
  logic          walk_left;
  logic          walk_right;
  logic          wall_we;
  logic [AW-1:0] wall_addr;
  logic          wall_set;
  logic          bump_left;
  logic          bump_right;
  logic [AW-1:0] pos;
  logic          wall_err;
  logic [15:0]   bounce_count;

  modport master (
    output enable, walk_left, walk_right, wall_we, wall_addr, wall_set,
    input  bump_left, bump_right, pos, wall_err, bounce_count
  );

  modport slave (
    input  enable, walk_left, walk_right, wall_we, wall_addr, wall_set,
    output bump_left, bump_right, pos, wall_err, bounce_count
  );
endinterface

// File: rtl/lemming_track.sv
// One-dimensional track world around the lemming walker: holds position and
// wall map, steps once per STEP_DIV cycles and pulses bump_* into walls/ends.
module lemming_track #(
  parameter int TRACK_LEN = 16,
  parameter int STEP_DIV  = 4,
  parameter int START_POS = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  lemming_track_if.slave trk
);
  localparam int AW = $clog2(TRACK_LEN);
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [AW-1:0] LAST_POS  = AW'(TRACK_LEN - 1);
  localparam logic [AW-1:0] RESET_POS = AW'(START_POS);
  localparam logic [CW-1:0] LAST_CNT  = CW'(STEP_DIV - 1);
  localparam logic [AW:0]   LEN_EXT   = (AW+1)'(TRACK_LEN);

  logic [AW-1:0]        pos_q, pos_d;
  logic [TRACK_LEN-1:0] wall_q, wall_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 bump_l_q, bump_l_d;
  logic                 bump_r_q, bump_r_d;
  logic                 wall_err_q, wall_err_d;
  logic [15:0]          bounce_q, bounce_d;

  logic tick, step_ok, left_blk, right_blk, wr_reject;

  // NOTE: combinational next-state uses blocking '=' with every output given a
  // default at the top, so no path can leave a signal unassigned (no latch).
  always_comb begin
    pos_d      = pos_q;
    wall_d     = wall_q;
    cnt_d      = cnt_q;
    bump_l_d   = 1'b0;
    bump_r_d   = 1'b0;
    wall_err_d = 1'b0;
    bounce_d   = bounce_q;

    tick    = trk.enable && (cnt_q == LAST_CNT);
    // A bump still on the wire means the walker has not turned yet.
    step_ok = tick && !(bump_l_q || bump_r_q) && (trk.walk_left ^ trk.walk_right);
    // Out-of-range neighbour reads only occur at the track ends, where the
    // end-of-track term already forces the result.
    left_blk  = (pos_q == '0)       || wall_q[pos_q - AW'(1)];
    right_blk = (pos_q == LAST_POS) || wall_q[pos_q + AW'(1)];
    wr_reject = ({1'b0, trk.wall_addr} >= LEN_EXT) ||
                (trk.wall_set && (trk.wall_addr == pos_q));

    if (trk.enable) cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);

    if (step_ok) begin
      if (trk.walk_left) begin
        if (left_blk) bump_l_d = 1'b1;
        else          pos_d    = pos_q - AW'(1);
      end else begin
        if (right_blk) bump_r_d = 1'b1;
        else           pos_d    = pos_q + AW'(1);
      end
    end

    if ((bump_l_d || bump_r_d) && (bounce_q != 16'hFFFF)) bounce_d = bounce_q + 16'd1;

    // The tick above already sampled the pre-write map and pre-move position.
    if (trk.wall_we) begin
      if (wr_reject) wall_err_d = 1'b1;
      else           wall_d[trk.wall_addr] = trk.wall_set;
    end
  end

  // NOTE: the wall map is a small flop vector, not a RAM, so it takes the
  // asynchronous reset like every other state bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= RESET_POS;
      wall_q     <= '0;
      cnt_q      <= '0;
      bump_l_q   <= 1'b0;
      bump_r_q   <= 1'b0;
      wall_err_q <= 1'b0;
      bounce_q   <= '0;
    end else begin
      pos_q      <= pos_d;
      wall_q     <= wall_d;
      cnt_q      <= cnt_d;
      bump_l_q   <= bump_l_d;
      bump_r_q   <= bump_r_d;
      wall_err_q <= wall_err_d;
      bounce_q   <= bounce_d;
    end
  end

  assign trk.pos          = pos_q;
  assign trk.bump_left    = bump_l_q;
  assign trk.bump_right   = bump_r_q;
  assign trk.wall_err     = wall_err_q;
  assign trk.bounce_count = bounce_q;
endmodule

// File: tb/tb_lemming_track.sv
// Bench for lemming_track: instance A (10 cells, STEP_DIV 2) under directed and
// random stimulus, instance B (8 cells, STEP_DIV 1) closed around a walker.
module tb_lemming_track;
  logic clk;
  logic rst_n;
  logic rst_b_n;

  lemming_track_if #(.TRACK_LEN(10)) ia ();
  lemming_track_if #(.TRACK_LEN(8))  ib ();

  lemming_track #(.TRACK_LEN(10), .STEP_DIV(2), .START_POS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .trk(ia.slave));
  lemming_track #(.TRACK_LEN(8), .STEP_DIV(1), .START_POS(0)) u_b (
    .clk(clk), .rst_n(rst_b_n), .trk(ib.slave));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position as a plain integer, walls as a bit set.
  typedef struct {
    int        pos;
    bit [15:0] wall;
    int        cnt;
    bit        bl;
    bit        br;
    bit        werr;
    int        bc;
  } mdl_t;

  function automatic mdl_t mdl_reset(input int start);
    mdl_t m;
    m.pos = start; m.wall = '0; m.cnt = 0;
    m.bl = 0; m.br = 0; m.werr = 0; m.bc = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int len, input int div,
                                    input bit en, input bit wl, input bit wr,
                                    input bit wwe, input int wa, input bit ws);
    mdl_t n;
    int   tgt;
    bit   tick;
    n = m;
    n.bl = 0; n.br = 0; n.werr = 0;
    tick = en && (m.cnt == div - 1);
    if (en) n.cnt = (m.cnt + 1) % div;
    if (tick && !(m.bl || m.br) && (wl != wr)) begin
      tgt = wl ? m.pos - 1 : m.pos + 1;
      if (tgt < 0 || tgt >= len || m.wall[tgt]) begin
        if (wl) n.bl = 1; else n.br = 1;
        if (m.bc < 65535) n.bc = m.bc + 1;
      end else begin
        n.pos = tgt;
      end
    end
    if (wwe) begin
      if (wa >= len || (ws && wa == m.pos)) n.werr = 1;
      else n.wall[wa] = ws;
    end
    return n;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ma = mdl_reset(3);
    else ma = mdl_step(ma, 10, 2, ia.enable, ia.walk_left, ia.walk_right,
                       ia.wall_we, int'(ia.wall_addr), ia.wall_set);

  always @(posedge clk or negedge rst_b_n)
    if (!rst_b_n) mb = mdl_reset(0);
    else mb = mdl_step(mb, 8, 1, ib.enable, ib.walk_left, ib.walk_right,
                       ib.wall_we, int'(ib.wall_addr), ib.wall_set);

  // Walker for instance B: starts left, turns on every bump it sees.
  logic dir_left;
  always @(negedge clk or negedge rst_b_n)
    if (!rst_b_n) dir_left = 1'b1;
    else if (ib.bump_left) dir_left = 1'b0;
    else if (ib.bump_right) dir_left = 1'b1;
  assign ib.walk_left  = dir_left;
  assign ib.walk_right = !dir_left;

  // Per-cycle compare against the model, plus bump alternation on B.
  int b_pulses  = 0;
  int last_side = -1;
  bit prev_bump = 0;
  always @(negedge clk) begin
    check("a_pos",  32'(ia.pos),          32'(ma.pos));
    check("a_bl",   32'(ia.bump_left),    32'(ma.bl));
    check("a_br",   32'(ia.bump_right),   32'(ma.br));
    check("a_werr", 32'(ia.wall_err),     32'(ma.werr));
    check("a_bc",   32'(ia.bounce_count), 32'(ma.bc));
    check("b_pos",  32'(ib.pos),          32'(mb.pos));
    check("b_bl",   32'(ib.bump_left),    32'(mb.bl));
    check("b_br",   32'(ib.bump_right),   32'(mb.br));
    check("b_bc",   32'(ib.bounce_count), 32'(mb.bc));
    if (rst_b_n) begin
      if (ib.bump_left || ib.bump_right) begin
        check("b_two_sides", 32'(ib.bump_left && ib.bump_right), 0);
        check("b_back2back", 32'(prev_bump), 0);
        if (last_side >= 0) check("b_alternate", 32'(ib.bump_right), 32'(last_side == 0));
        last_side = ib.bump_right ? 1 : 0;
        b_pulses++;
      end
      prev_bump = ib.bump_left || ib.bump_right;
    end
  end

  // Closed-loop literal expectations on B.
  initial begin
    @(posedge rst_b_n);
    @(negedge clk);
    check("b_first_bump_left", 32'(ib.bump_left), 1);
    repeat (8) @(negedge clk);
    check("b_ramp_pos7", 32'(ib.pos), 7);
    @(negedge clk);
    check("b_bump_right_at_end", 32'(ib.bump_right), 1);
  end

  task automatic set_a(input bit en, input bit wl, input bit wr,
                       input bit we, input int addr, input bit set);
    ia.enable = en; ia.walk_left = wl; ia.walk_right = wr;
    ia.wall_we = we; ia.wall_addr = 4'(addr); ia.wall_set = set;
  endtask

  initial begin
    clk = 0; rst_n = 0; rst_b_n = 0;
    set_a(0, 0, 0, 0, 0, 0);
    ib.enable = 1; ib.wall_we = 0; ib.wall_addr = '0; ib.wall_set = 0;
    repeat (2) @(negedge clk);
    check("rst_pos",  32'(ia.pos), 3);
    check("rst_bump", 32'({ia.bump_left, ia.bump_right}), 0);
    check("rst_werr", 32'(ia.wall_err), 0);
    check("rst_bc",   32'(ia.bounce_count), 0);

    // Walk left into the end: 3->2->1->0 then bump at cycle 7.
    rst_n = 1; rst_b_n = 1;
    set_a(1, 1, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    check("left_end_bump", 32'(ia.bump_left), 1);
    check("left_end_pos",  32'(ia.pos), 0);
    check("left_end_bc",   32'(ia.bounce_count), 1);

    // Walk right back to 3, then wall at 5.
    set_a(1, 0, 1, 0, 0, 0);
    repeat (6) @(negedge clk);
    check("back_to_3", 32'(ia.pos), 3);
    set_a(1, 0, 1, 1, 5, 1);
    @(negedge clk);
    set_a(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("wall_approach_pos4", 32'(ia.pos), 4);
    repeat (2) @(negedge clk);
    check("wall_bump_right", 32'(ia.bump_right), 1);
    check("wall_bump_pos4",  32'(ia.pos), 4);
    set_a(1, 0, 1, 1, 5, 0);
    @(negedge clk);
    set_a(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("wall_cleared_pos5", 32'(ia.pos), 5);

    // Wall-write rejection cases, no walking.
    set_a(1, 0, 0, 1, 5, 1);
    @(negedge clk);
    check("werr_at_pos", 32'(ia.wall_err), 1);
    set_a(1, 0, 0, 1, 12, 0);
    @(negedge clk);
    check("werr_addr_range", 32'(ia.wall_err), 1);
    set_a(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("werr_single_cycle", 32'(ia.wall_err), 0);
    set_a(1, 0, 0, 1, 2, 1);
    @(negedge clk);
    check("werr_ok_addr2", 32'(ia.wall_err), 0);
    set_a(1, 0, 0, 1, 9, 1);
    @(negedge clk);
    check("werr_ok_addr9", 32'(ia.wall_err), 0);
    set_a(1, 0, 0, 1, 2, 0);
    @(negedge clk);
    set_a(1, 0, 0, 1, 9, 0);
    @(negedge clk);

    // Both directions, then neither: no motion.
    set_a(1, 1, 1, 0, 0, 0);
    repeat (10) @(negedge clk);
    check("both_hold_pos", 32'(ia.pos), 5);
    set_a(1, 0, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    check("none_hold_pos", 32'(ia.pos), 5);

    // Asynchronous reset between edges.
    #2 rst_n = 0;
    #1;
    check("async_rst_pos", 32'(ia.pos), 3);
    check("async_rst_bc",  32'(ia.bounce_count), 0);
    @(negedge clk);
    rst_n = 1;

    // Freeze the step timer mid-period.
    set_a(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    set_a(0, 0, 1, 0, 0, 0);
    repeat (6) @(negedge clk);
    check("frozen_pos", 32'(ia.pos), 3);
    set_a(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("resume_tick_pos", 32'(ia.pos), 4);

    // Randomised traffic checked by the per-cycle compare.
    for (int i = 0; i < 800; i++) begin
      set_a($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    set_a(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    check("b_bc_matches_pulses", 32'(ib.bounce_count), 32'(b_pulses));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
